// File: rtl/or1200_fwd_sel_if.sv
// ----------------------------------------------------------------------------
// or1200_fwd_sel_if
// Bundles the pipeline-control, instruction-decode and forwarding-select
// signals of the forwarding-select generator.
//   master : pipeline side, drives freezes/flush and the if_* decode fields,
//            receives sel_a/sel_b, lu_stall, tracked destinations and lu_cnt.
//   slave  : the or1200_fwd_sel block itself.
// Parameters: AW register address width, CW stall counter width.
// ----------------------------------------------------------------------------
interface or1200_fwd_sel_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
);
    logic          id_freeze;
    logic          ex_freeze;
    logic          wb_freeze;
    logic          flushpipe;
    logic [AW-1:0] if_rfa_addr;
    logic [AW-1:0] if_rfb_addr;
    logic          if_rfa_en;
    logic          if_rfb_en;
    logic          if_imm_sel;
    logic [AW-1:0] if_rfwb_addr;
    logic          if_rfwb_en;
    logic          if_is_load;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic          lu_stall;
    logic [AW-1:0] ex_rfwb_addr;
    logic          ex_rfwb_en;
    logic [AW-1:0] wb_rfwb_addr;
    logic          wb_rfwb_en;
    logic [CW-1:0] lu_cnt;

    modport master (
        output id_freeze, ex_freeze, wb_freeze, flushpipe,
        output if_rfa_addr, if_rfb_addr, if_rfa_en, if_rfb_en, if_imm_sel,
        output if_rfwb_addr, if_rfwb_en, if_is_load,
        input  sel_a, sel_b, lu_stall,
        input  ex_rfwb_addr, ex_rfwb_en, wb_rfwb_addr, wb_rfwb_en, lu_cnt
    );

    modport slave (
        input  id_freeze, ex_freeze, wb_freeze, flushpipe,
        input  if_rfa_addr, if_rfb_addr, if_rfa_en, if_rfb_en, if_imm_sel,
        input  if_rfwb_addr, if_rfwb_en, if_is_load,
        output sel_a, sel_b, lu_stall,
        output ex_rfwb_addr, ex_rfwb_en, wb_rfwb_addr, wb_rfwb_en, lu_cnt
    );
endinterface

// File: rtl/or1200_fwd_sel.sv
// ----------------------------------------------------------------------------
// or1200_fwd_sel
// Forwarding-select generator for the operand muxes. Tracks the register-file
// write destinations held in ID, EX and WB, compares the source fields of the
// instruction entering ID against the ID/EX destinations, and registers
// sel_a/sel_b so they are valid during that instruction's ID cycle. Detects
// load-use hazards (one-cycle lu_stall pulse) and counts them (saturating).
//
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset, overrides flush and freezes
//   bus  : or1200_fwd_sel_if.slave
//          in : id/ex/wb_freeze, flushpipe, if_rf{a,b}_addr/_en, if_imm_sel,
//               if_rfwb_addr/_en, if_is_load
//          out: sel_a/sel_b (0 RF, 1 IMM, 2 EX_FORW, 3 WB_FORW), lu_stall,
//               ex/wb_rfwb_addr/_en, lu_cnt
//
// Build option: OR1200_FWD_R0_ZERO_EN -- when defined, r0 never matches a
// destination, so r0 reads select RF (or IMM) and r0 loads never stall.
// ----------------------------------------------------------------------------
module or1200_fwd_sel #(
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
) (
    input logic             clk,
    input logic             rst,
    or1200_fwd_sel_if.slave bus
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_EX  = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    // Destination tracking
    logic [AW-1:0] id_addr;
    logic          id_en;
    logic          id_ld;
    logic [AW-1:0] ex_addr;
    logic          ex_en;
    logic [AW-1:0] wb_addr;
    logic          wb_en;

    // Registered outputs
    logic [1:0]    sel_a_q;
    logic [1:0]    sel_b_q;
    logic          lu_stall_q;
    logic [CW-1:0] lu_cnt_q;

    // Compare results
    logic          a_ok;
    logic          b_ok;
    logic          m_a_id;
    logic          m_a_ex;
    logic          m_b_id;
    logic          m_b_ex;
    logic [1:0]    sel_a_nxt;
    logic [1:0]    sel_b_nxt;
    logic [1:0]    sel_a_rw;
    logic [1:0]    sel_b_rw;
    logic          hazard;

`ifdef OR1200_FWD_R0_ZERO_EN
    assign a_ok = |bus.if_rfa_addr;
    assign b_ok = |bus.if_rfb_addr;
`else
    assign a_ok = 1'b1;
    assign b_ok = 1'b1;
`endif

    always_comb begin
        m_a_id = bus.if_rfa_en && a_ok && id_en && (bus.if_rfa_addr == id_addr);
        m_a_ex = bus.if_rfa_en && a_ok && ex_en && (bus.if_rfa_addr == ex_addr);
        m_b_id = bus.if_rfb_en && b_ok && id_en && (bus.if_rfb_addr == id_addr);
        m_b_ex = bus.if_rfb_en && b_ok && ex_en && (bus.if_rfb_addr == ex_addr);

        // Youngest producer (ID) wins over EX; immediate wins over everything on B
        sel_a_nxt = m_a_id ? SEL_EX : (m_a_ex ? SEL_WB : SEL_RF);
        if (bus.if_imm_sel) begin
            sel_b_nxt = SEL_IMM;
        end else begin
            sel_b_nxt = m_b_id ? SEL_EX : (m_b_ex ? SEL_WB : SEL_RF);
        end

        hazard = id_ld && (m_a_id || (m_b_id && !bus.if_imm_sel));

        // During a stall the load advances to WB, so EX forwarding becomes WB forwarding
        sel_a_rw = (sel_a_q == SEL_EX) ? SEL_WB : sel_a_q;
        sel_b_rw = (sel_b_q == SEL_EX) ? SEL_WB : sel_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_addr    <= '0;
            id_en      <= 1'b0;
            id_ld      <= 1'b0;
            ex_addr    <= '0;
            ex_en      <= 1'b0;
            wb_addr    <= '0;
            wb_en      <= 1'b0;
            sel_a_q    <= SEL_RF;
            sel_b_q    <= SEL_RF;
            lu_stall_q <= 1'b0;
            lu_cnt_q   <= '0;
        end else begin
            if (!bus.id_freeze) begin
                id_addr <= bus.if_rfwb_addr;
                id_en   <= bus.if_rfwb_en;
                id_ld   <= bus.if_is_load;
            end

            // A frozen ID stage feeds a bubble into a running EX stage
            if (!bus.ex_freeze) begin
                ex_addr <= id_addr;
                ex_en   <= id_en && !bus.id_freeze;
            end

            if (!bus.wb_freeze) begin
                wb_addr <= ex_addr;
                wb_en   <= ex_en && !bus.ex_freeze;
            end

            // The stall rewrite takes precedence over a new compare so that a
            // stall pulse is always followed by the EX->WB promotion.
            if (lu_stall_q) begin
                sel_a_q <= sel_a_rw;
                sel_b_q <= sel_b_rw;
            end else if (!bus.id_freeze) begin
                sel_a_q <= sel_a_nxt;
                sel_b_q <= sel_b_nxt;
            end

            lu_stall_q <= !lu_stall_q && !bus.id_freeze && hazard;

            if (lu_stall_q && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + CW'(1);
            end

            // Flush overrides freezes; WB still follows the rules above
            if (bus.flushpipe) begin
                id_en      <= 1'b0;
                ex_en      <= 1'b0;
                sel_a_q    <= SEL_RF;
                sel_b_q    <= SEL_RF;
                lu_stall_q <= 1'b0;
            end
        end
    end

    assign bus.sel_a        = sel_a_q;
    assign bus.sel_b        = sel_b_q;
    assign bus.lu_stall     = lu_stall_q;
    assign bus.ex_rfwb_addr = ex_addr;
    assign bus.ex_rfwb_en   = ex_en;
    assign bus.wb_rfwb_addr = wb_addr;
    assign bus.wb_rfwb_en   = wb_en;
    assign bus.lu_cnt       = lu_cnt_q;

endmodule
